// File: rtl/axis_uart_tx_arb_pkg.sv
// Shared UART package: types and constants for the TX stream arbiter.
package axis_uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE_ARB,
    HEADER_ARB,
    PAYLOAD_ARB
  } uart_arb_state_e;

  localparam logic [3:0]  UART_ARB_HDR_TAG = 4'hA;
  localparam int unsigned UART_ARB_MAX_SRC = 16;

endpackage

// File: rtl/axis_uart_tx_arb_round_robin_arbiter.sv
// Combinational round-robin priority rotation: first requester after last_i wins.
module round_robin_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] idx_o
);

  logic            found;
  logic [IDXW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = IDXW'((32'(last_i) + i) % N);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/axis_uart_tx_arb.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream UART TX among N_SRC sources,
// with an optional per-grant channel header byte and a registered output stage.
module axis_uart_tx_arb
  import axis_uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned HEADER_EN  = 1,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [N_SRC-1:0]            s_axis_tvalid_i,
  input  logic [N_SRC-1:0]            s_axis_tlast_i,
  output logic [N_SRC-1:0]            s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata_o,
  output logic                        m_axis_tvalid_o,
  input  logic                        m_axis_tready_i,
  output logic [N_SRC-1:0]            grant_o,
  output logic                        busy_o
);

  localparam int unsigned IDXW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CNTW = $clog2(MAX_BURST + 1);
  localparam int unsigned HIW  = $clog2(UART_ARB_MAX_SRC);

  uart_arb_state_e       state_q, state_d;
  logic [N_SRC-1:0]      grant_q, grant_d;
  logic [IDXW-1:0]       gidx_q, gidx_d;
  logic [IDXW-1:0]       last_q, last_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;

  logic [N_SRC-1:0]      arb_gnt;
  logic [IDXW-1:0]       arb_idx;
  logic [N_SRC-1:0]      s_ready;
  logic                  out_free;

  round_robin_arbiter #(
    .N    (N_SRC),
    .IDXW (IDXW)
  ) u_rr (
    .req_i  (s_axis_tvalid_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  assign out_free = !tvalid_q || m_axis_tready_i;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q && !m_axis_tready_i;
    s_ready  = '0;
    case (state_q)
      IDLE_ARB: begin
        if (|s_axis_tvalid_i) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          state_d = (HEADER_EN != 0) ? HEADER_ARB : PAYLOAD_ARB;
        end
      end
      HEADER_ARB: begin
        if (out_free) begin
          tdata_d  = DATA_WIDTH'({UART_ARB_HDR_TAG, HIW'(gidx_q)});
          tvalid_d = 1'b1;
          state_d  = PAYLOAD_ARB;
        end
      end
      PAYLOAD_ARB: begin
        // Ready follows the output register directly so a stalled UART never loses a byte.
        s_ready[gidx_q] = out_free;
        if (out_free && s_axis_tvalid_i[gidx_q]) begin
          tdata_d  = s_axis_tdata_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];
          tvalid_d = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (s_axis_tlast_i[gidx_q] || cnt_q == CNTW'(MAX_BURST - 1)) begin
            last_d  = gidx_q;
            cnt_d   = '0;
            grant_d = '0;
            state_d = IDLE_ARB;
          end
        end
      end
      default: state_d = IDLE_ARB;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE_ARB;
      grant_q  <= '0;
      gidx_q   <= '0;
      last_q   <= IDXW'(N_SRC - 1);
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign s_axis_tready_o = s_ready;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q != IDLE_ARB) || tvalid_q;

endmodule
